alu_sequencer: RTL and testbench

- Instruction-driven controller that issues operations to the combinational ALU and collects its results. It is the driver side of the ALU's opcode/operand interface.
- Accepts 16-bit instructions over a valid/ready stream and reads operands from a 4-entry register file.
- Drives the ALU ports, samples y and the flags, writes the result back and returns it on a valid/ready response stream.
- Sits between a host/test sequencer and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 47 ++++
 rtl/alu_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction stream, ALU drive/sample and response stream of alu_sequencer.
// slave = sequencer side, master = host/ALU side.
interface alu_sequencer_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_instr;

  logic [3:0]           alu_opcode;
  logic [BUS_WIDTH-1:0] alu_a;
  logic [BUS_WIDTH-1:0] alu_b;
  logic                 alu_carry_in;
  logic [BUS_WIDTH-1:0] alu_y;
  logic                 alu_carry_out;
  logic                 alu_borrow;
  logic                 alu_zero;
  logic                 alu_parity;
  logic                 alu_invalid_op;

  logic                 res_valid;
  logic                 res_ready;
  logic [BUS_WIDTH-1:0] res_data;
  logic                 res_zero;
  logic                 res_parity;
  logic                 res_carry;
  logic                 res_borrow;
  logic                 res_err;

  modport slave (
    input  in_valid, in_instr,
    output in_ready,
    output alu_opcode, alu_a, alu_b, alu_carry_in,
    input  alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    output res_valid, res_data, res_zero, res_parity, res_carry, res_borrow, res_err,
    input  res_ready
  );

  modport master (
    output in_valid, in_instr,
    input  in_ready,
    input  alu_opcode, alu_a, alu_b, alu_carry_in,
    output alu_y, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op,
    input  res_valid, res_data, res_zero, res_parity, res_carry, res_borrow, res_err,
    output res_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving a combinational ALU from a 4-entry register file.
// Optional macro ALU_SEQUENCER_HALT_EN turns opcode 4'hE into a terminal HALT.
module alu_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_ADC   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_INC   = 4'h4;
  localparam logic [3:0] OP_DEC   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_LOADI = 4'hF;

  function automatic logic parity_of(input logic [BUS_WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [1:0]           state_r;
  logic [1:0]           state_next_s;
  logic [1:0]           rd_r;
  logic [3:0]           op_r;
  logic                 carry_flag_r;
  logic [BUS_WIDTH-1:0] regs_r [4];
  logic                 in_ready_r;

  logic [3:0]           alu_opcode_r;
  logic [BUS_WIDTH-1:0] alu_a_r;
  logic [BUS_WIDTH-1:0] alu_b_r;
  logic                 alu_carry_in_r;

  logic                 res_valid_r;
  logic [BUS_WIDTH-1:0] res_data_r;
  logic                 res_zero_r;
  logic                 res_parity_r;
  logic                 res_carry_r;
  logic                 res_borrow_r;
  logic                 res_err_r;

  logic                 accept_s;
  logic [3:0]           op_in_s;
  logic                 is_local_s;
  logic                 is_halt_s;
  logic                 is_alu_s;
  logic [BUS_WIDTH-1:0] imm_ext_s;

  // Decode the instruction offered on the input stream
  always_comb begin
    accept_s   = bus.in_valid & in_ready_r;
    op_in_s    = bus.in_instr[15:12];
    is_local_s = (op_in_s == OP_LOADI) || (op_in_s == OP_NOP);
`ifdef ALU_SEQUENCER_HALT_EN
    is_halt_s  = (op_in_s == OP_HALT);
`else
    is_halt_s  = 1'b0;
`endif
    is_alu_s   = ~is_local_s & ~is_halt_s;
    imm_ext_s  = '0;
    imm_ext_s[7:0] = bus.in_instr[7:0];
  end

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_halt_s) begin
            state_next_s = ST_HALT;
          end else if (is_local_s) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_EXEC;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_RESP;
      ST_RESP: begin
        if (res_valid_r && bus.res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, accept readiness and latched instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      rd_r       <= 2'd0;
      op_r       <= 4'h0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == ST_IDLE);
      if (state_r == ST_IDLE && accept_s) begin
        rd_r <= bus.in_instr[11:10];
        op_r <= op_in_s;
      end
    end
  end

  // ALU drive: loaded on entry to EXEC, cleared everywhere else so it is live for one cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_r   <= 4'h0;
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_carry_in_r <= 1'b0;
    end else if (state_r == ST_IDLE && accept_s && is_alu_s) begin
      alu_opcode_r   <= op_in_s;
      alu_a_r        <= regs_r[bus.in_instr[9:8]];
      alu_b_r        <= regs_r[bus.in_instr[7:6]];
      alu_carry_in_r <= (op_in_s == OP_ADC) ? carry_flag_r : 1'b0;
    end else begin
      alu_opcode_r   <= 4'h0;
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_carry_in_r <= 1'b0;
    end
  end

  // Response registers: filled at accept (LOADI/NOP) or at the end of EXEC, held until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r  <= 1'b0;
      res_data_r   <= '0;
      res_zero_r   <= 1'b0;
      res_parity_r <= 1'b0;
      res_carry_r  <= 1'b0;
      res_borrow_r <= 1'b0;
      res_err_r    <= 1'b0;
    end else if (state_r == ST_IDLE && accept_s && is_local_s) begin
      res_valid_r  <= 1'b1;
      res_carry_r  <= 1'b0;
      res_borrow_r <= 1'b0;
      res_err_r    <= 1'b0;
      if (op_in_s == OP_LOADI) begin
        res_data_r   <= imm_ext_s;
        res_zero_r   <= (imm_ext_s == '0);
        res_parity_r <= parity_of(imm_ext_s);
      end else begin
        res_data_r   <= '0;
        res_zero_r   <= 1'b1;
        res_parity_r <= 1'b0;
      end
    end else if (state_r == ST_EXEC) begin
      res_valid_r  <= 1'b1;
      res_data_r   <= bus.alu_y;
      res_zero_r   <= bus.alu_zero;
      res_parity_r <= bus.alu_parity;
      res_carry_r  <= bus.alu_carry_out;
      res_borrow_r <= bus.alu_borrow;
      res_err_r    <= bus.alu_invalid_op;
    end else if (state_r == ST_RESP && bus.res_ready) begin
      res_valid_r  <= 1'b0;
    end else begin
      res_valid_r  <= res_valid_r;
    end
  end

  // Register file and carry flag; operands were captured before this write, so rd==rs is safe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= '0;
      end
      carry_flag_r <= 1'b0;
    end else if (state_r == ST_IDLE && accept_s && op_in_s == OP_LOADI) begin
      regs_r[bus.in_instr[11:10]] <= imm_ext_s;
    end else if (state_r == ST_EXEC && !bus.alu_invalid_op) begin
      regs_r[rd_r] <= bus.alu_y;
      case (op_r)
        OP_ADD, OP_ADC, OP_INC: carry_flag_r <= bus.alu_carry_out;
        OP_SUB, OP_DEC:         carry_flag_r <= bus.alu_borrow;
        default:                carry_flag_r <= carry_flag_r;
      endcase
    end else begin
      carry_flag_r <= carry_flag_r;
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.alu_opcode   = alu_opcode_r;
  assign bus.alu_a        = alu_a_r;
  assign bus.alu_b        = alu_b_r;
  assign bus.alu_carry_in = alu_carry_in_r;
  assign bus.res_valid    = res_valid_r;
  assign bus.res_data     = res_data_r;
  assign bus.res_zero     = res_zero_r;
  assign bus.res_parity   = res_parity_r;
  assign bus.res_carry    = res_carry_r;
  assign bus.res_borrow   = res_borrow_r;
  assign bus.res_err      = res_err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached to its ALU ports.
module tb_alu_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BUS_WIDTH(W)) bus ();
  alu_sequencer #(.BUS_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       parity;
    logic       carry;
    logic       borrow;
    logic       err;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_got;
  resp_t mon_exp;
  int checks = 0;
  int failures = 0;

  // Behavioural ALU: 1 add, 2 add+cin, 3 sub, 4 inc, 5 dec, 6 and, 7 or, 8 rol, 9 xor, 10..14 invalid
  always_comb begin
    logic [8:0] s;
    s = 9'd0;
    bus.alu_y = 8'd0;
    bus.alu_carry_out = 1'b0;
    bus.alu_borrow = 1'b0;
    bus.alu_invalid_op = 1'b0;
    case (bus.alu_opcode)
      4'h1: begin s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; bus.alu_y = s[7:0]; bus.alu_carry_out = s[8]; end
      4'h2: begin s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_carry_in}; bus.alu_y = s[7:0]; bus.alu_carry_out = s[8]; end
      4'h3: begin bus.alu_y = bus.alu_a - bus.alu_b; bus.alu_borrow = (bus.alu_a < bus.alu_b); end
      4'h4: begin s = {1'b0, bus.alu_a} + 9'd1; bus.alu_y = s[7:0]; bus.alu_carry_out = s[8]; end
      4'h5: begin bus.alu_y = bus.alu_a - 8'd1; bus.alu_borrow = (bus.alu_a == 8'd0); end
      4'h6: bus.alu_y = bus.alu_a & bus.alu_b;
      4'h7: bus.alu_y = bus.alu_a | bus.alu_b;
      4'h8: begin bus.alu_y = {bus.alu_a[6:0], bus.alu_a[7]}; bus.alu_carry_out = bus.alu_a[7]; end
      4'h9: bus.alu_y = bus.alu_a ^ bus.alu_b;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: bus.alu_invalid_op = 1'b1;
      default: bus.alu_y = 8'd0;
    endcase
    bus.alu_zero = (bus.alu_y == 8'd0);
    bus.alu_parity = ^bus.alu_y;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [7:0] d, input logic z, input logic p,
                             input logic c, input logic b, input logic e);
    resp_t r;
    r = {d, z, p, c, b, e};
    exp_q.push_back(r);
  endtask

  // Waits (bounded) for in_ready, then offers one instruction for exactly one accepting edge
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: in_ready=%b expected 1 for instr %h", bus.in_ready, ins);
    end
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%b expected 0 and 1", exp_q.size(), bus.in_ready);
    end
  endtask

  // Monitor: every accepted response is popped against the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      mon_got = {bus.res_data, bus.res_zero, bus.res_parity, bus.res_carry, bus.res_borrow, bus.res_err};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_response: actual=%h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL response: actual data=%0d z=%b p=%b c=%b b=%b e=%b expected data=%0d z=%b p=%b c=%b b=%b e=%b",
                   mon_got.data, mon_got.zero, mon_got.parity, mon_got.carry, mon_got.borrow, mon_got.err,
                   mon_exp.data, mon_exp.zero, mon_exp.parity, mon_exp.carry, mon_exp.borrow, mon_exp.err);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0000;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_alu_opcode", bus.alu_opcode, 0);
    check("rst_alu_ab", {bus.alu_a, bus.alu_b, bus.alu_carry_in}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready, 1);

    // LOADI R0=9, R1=33, ADD R2=R0+R1 with latency/drive checks
    expect_resp(8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   issue(16'hF009);
    expect_resp(8'd33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'hF421);
    drain();
    expect_resp(8'd42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(16'h1840);
    @(negedge clk);
    check("add_exec_opcode", bus.alu_opcode, 1);
    check("add_exec_ab", {bus.alu_a, bus.alu_b}, {8'd9, 8'd33});
    check("add_exec_no_valid", bus.res_valid, 0);
    @(negedge clk);
    check("add_resp_valid", bus.res_valid, 1);
    check("add_resp_opcode_idle", bus.alu_opcode, 0);
    drain();

    // INC with carry out, then ADD_CARRY consumes it
    expect_resp(8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); issue(16'hF0FF);
    expect_resp(8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   issue(16'h4C00);
    expect_resp(8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   issue(16'hF009);
    expect_resp(8'd33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'hF421);
    drain();
    expect_resp(8'd43, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(16'h2840);
    @(negedge clk);
    check("adc_carry_in_after_inc", bus.alu_carry_in, 1);
    drain();

    // SUB with borrow sets carry_flag, seen by the next ADD_CARRY
    expect_resp(8'd65, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'hF041);
    expect_resp(8'd66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'hF442);
    expect_resp(8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); issue(16'h3840);
    drain();
    expect_resp(8'd132, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(16'h2C40);
    @(negedge clk);
    check("adc_carry_in_after_sub", bus.alu_carry_in, 1);
    drain();

    // Invalid opcode: error, no writeback; ROL of R2 shows the old 42
    expect_resp(8'd42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  issue(16'hF82A);
    expect_resp(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   issue(16'hAA80);
    expect_resp(8'd84, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  issue(16'h8E00);
    expect_resp(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   issue(16'h0000);
    drain();

    // Backpressure: response held, in_valid pulses ignored
    bus.res_ready = 1'b0;
    expect_resp(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(16'hF45A);
    @(negedge clk);
    check("bp_valid_seen", bus.res_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i % 2 == 0);
      bus.in_instr = 16'hF411;
      @(negedge clk);
      check("bp_hold", {bus.res_valid, bus.in_ready, bus.res_data}, {1'b1, 1'b0, 8'h5A});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'h0000;
    bus.res_ready = 1'b1;
    drain();
    expect_resp(8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'h8100);
    drain();

    // Reset during EXEC of an ADD: nothing written, nothing returned
    expect_resp(8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   issue(16'hF009);
    expect_resp(8'd33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  issue(16'hF421);
    drain();
    issue(16'h1840);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {bus.res_valid, bus.in_ready, bus.alu_opcode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", bus.in_ready, 1);
    repeat (4) @(negedge clk);
    expect_resp(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   issue(16'h8E00);
    drain();

`ifdef ALU_SEQUENCER_HALT_EN
    // HALT: no response, never ready again
    issue(16'hE000);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'hF011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halted", {bus.in_ready, bus.res_valid}, 0);
    end
    bus.in_valid = 1'b0;
`else
    expect_resp(8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   issue(16'hE000);
    drain();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
